radix2_divider: RTL and testbench
=================================

RADIX2_DIVIDER -- requirements
Module: radix2_divider

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 64, giving the operand width in bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 valid  input  1  start request from the ALU; level-held by the requester until done.
REQ-005 a  input  WIDTH  dividend, unsigned.
REQ-006 b  input  WIDTH  divisor, unsigned.
REQ-007 done  output  1  result-valid pulse, one cycle wide.
REQ-008 c  output  2*WIDTH  {remainder, quotient}: c[2W-1:W] is the remainder and c[W-1:0] is the quotient.

Function
REQ-009 The block SHALL use an FSM with states IDLE, BUSY and DONE.
REQ-010 In IDLE, valid=1 at a rising edge SHALL latch a and b, clear the remainder, load the quotient with a, zero the 6-bit counter, and move to BUSY.
REQ-011 In IDLE, valid=0 SHALL keep the FSM in IDLE with no state change.
REQ-012 In BUSY, each cycle SHALL perform one restoring step:
- shift {rem,quo} left by one;
- trial = rem_shifted - divisor, computed at WIDTH+1 bits;
- if trial is non-negative, rem = trial and quo[0] = 1; otherwise rem = rem_shifted and quo[0] = 0.
REQ-013 BUSY SHALL last exactly WIDTH cycles; when counter = WIDTH-1, the next state SHALL be DONE.
REQ-014 valid SHALL be ignored in BUSY and DONE; an operation, once accepted, always runs to completion.
REQ-015 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-016 Latency: done SHALL be high in the (WIDTH+1)th cycle after the accepting edge, i.e. 65 cycles for WIDTH=64.
REQ-017 c SHALL be driven from the result registers and SHALL hold the last result until the next accept; it is valid only while done=1 (and stable afterwards).
REQ-018 Back-to-back: valid=1 in the IDLE cycle immediately after DONE SHALL start a new operation with no extra bubble.
REQ-019 Divisor zero SHALL produce quotient all-ones and remainder = a, as the natural outcome of the algorithm (no special case).
REQ-020 The block SHALL be unsigned only; sign handling and W-variant width handling stay in the ALU.

Reset
REQ-021 When resetn=0, the FSM SHALL go to IDLE, the counter to 0, done to 0, and c and all internal registers to 0, asynchronously.
REQ-022 Reset asserted mid-BUSY SHALL abandon the operation with no done pulse.
REQ-023 After resetn rises, the first accept SHALL require valid=1 at a subsequent rising edge.

Structure
REQ-024 The FSM state enum (IDLE/BUSY/DONE) and DIV_WIDTH=64 SHALL live in the shared common package.
REQ-025 The block SHALL be a single module with no sub-module; the one-bit restoring step is inline combinational logic.
REQ-026 The datapath SHALL be one WIDTH-bit remainder register, one WIDTH-bit quotient register, one divisor register and one subtractor.

Verification
REQ-027 a=100, b=7, valid held → done exactly 65 cycles after accept, c={64'd2, 64'd14}.
REQ-028 a=5, b=0 → c={64'd5, 64'hFFFF_FFFF_FFFF_FFFF}.
REQ-029 a=64'hFFFF_FFFF_FFFF_FFFF, b=1 → quotient all-ones, remainder 0; then a=3, b=64'h8000_0000_0000_0000 → quotient 0, remainder 3.
REQ-030 Two operations back-to-back (valid high continuously) → two done pulses exactly 66 cycles apart; b changed mid-BUSY does not affect the first result.
REQ-031 resetn pulsed low at BUSY cycle 30 → done and c read 0 immediately, no done pulse; a following 42/6 gives c={64'd0, 64'd7}.
REQ-032 Random a,b, 10k operations against a reference model → quotient*b+remainder == a and remainder < b whenever b != 0.

Source files
------------

// File: rtl/radix2_divider_pkg.sv
// Shared definitions for the restoring radix-2 divider.
// Holds the default operand width and the FSM state encoding.
package radix2_divider_pkg;

    localparam int DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_e;

endpackage

// File: rtl/radix2_divider_if.sv
// Request/result bundle between the ALU and the divider.
// The ALU holds valid high until it sees the one-cycle done pulse.
interface radix2_divider_if
    import radix2_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic               valid;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               done;
    logic [2*WIDTH-1:0] c;

    modport master (
        output valid, a, b,
        input  done, c
    );

    modport slave (
        input  valid, a, b,
        output done, c
    );

endinterface

// File: rtl/radix2_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Result c = {remainder, quotient}, valid while done is high.
module radix2_divider
    import radix2_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic              clk,
    input  logic              resetn,
    radix2_divider_if.slave   bus
);

    localparam logic [5:0] CNT_LAST = 6'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;

    logic [WIDTH:0]   shift_w;
    logic [WIDTH:0]   trial_w;

    // Trial subtract at WIDTH+1 bits; the top bit is the borrow.
    assign shift_w = {rem_q, quo_q[WIDTH-1]};
    assign trial_w = shift_w - {1'b0, div_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    div_d   = bus.b;
                    rem_d   = '0;
                    quo_d   = bus.a;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                quo_d = {quo_q[WIDTH-2:0], ~trial_w[WIDTH]};
                rem_d = trial_w[WIDTH] ? shift_w[WIDTH-1:0]
                                       : trial_w[WIDTH-1:0];
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
        end
    end

    assign bus.done = (state_q == DONE);
    assign bus.c    = {rem_q, quo_q};

endmodule

// File: tb/tb_radix2_divider.sv
// Directed bench for radix2_divider at WIDTH=64.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_radix2_divider;

    localparam int W = 64;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    radix2_divider_if #(.WIDTH(W)) bus ();

    radix2_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns cycles to done.
    task automatic do_op(input logic [W-1:0] av,
                         input logic [W-1:0] bv,
                         output int lat);
        bus.valid = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.done && lat < 200);
        bus.valid = 1'b0;
    endtask

    task automatic op_check(input string tag,
                            input logic [W-1:0] av,
                            input logic [W-1:0] bv,
                            input logic [W-1:0] rem,
                            input logic [W-1:0] quo);
        int lat;
        do_op(av, bv, lat);
        check({tag, " latency"}, 128'(lat), 128'd65);
        check({tag, " result"}, bus.c, {rem, quo});
        @(negedge clk);
        check({tag, " done width"}, 128'(bus.done), 128'd0);
        check({tag, " c hold"}, bus.c, {rem, quo});
    endtask

    initial begin
        int lat;
        int gap;
        int pulses;
        logic [W-1:0] ra, rb, rq, rr;

        bus.valid = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(negedge clk);
        check("reset done", 128'(bus.done), 128'd0);
        check("reset c", bus.c, 128'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle done", 128'(bus.done), 128'd0);
        check("idle c", bus.c, 128'd0);

        op_check("100/7", 64'd100, 64'd7, 64'd2, 64'd14);
        op_check("5/0", 64'd5, 64'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        op_check("max/1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        op_check("3/msb", 64'd3, 64'h8000_0000_0000_0000,
                 64'd3, 64'd0);

        // Back-to-back with valid held; divisor changes mid-operation.
        bus.valid = 1'b1;
        bus.a     = 64'd1000;
        bus.b     = 64'd9;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 20) bus.b = 64'd3;
        end while (!bus.done && lat < 200);
        check("b2b first latency", 128'(lat), 128'd65);
        check("b2b first result", bus.c, {64'd1, 64'd111});
        bus.a = 64'd50;
        gap   = 0;
        pulses = 0;
        do begin
            @(negedge clk);
            gap++;
            if (bus.done) pulses++;
        end while (!bus.done && gap < 200);
        bus.valid = 1'b0;
        check("b2b gap", 128'(gap), 128'd66);
        check("b2b second result", bus.c, {64'd2, 64'd16});
        @(negedge clk);

        // Reset in the middle of an operation.
        bus.valid = 1'b1;
        bus.a     = 64'd1234;
        bus.b     = 64'd5;
        repeat (30) @(negedge clk);
        resetn    = 1'b0;
        bus.valid = 1'b0;
        #1;
        check("midreset done", 128'(bus.done), 128'd0);
        check("midreset c", bus.c, 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("midreset no pulse", 128'(pulses), 128'd0);
        op_check("42/6", 64'd42, 64'd6, 64'd0, 64'd7);

        // Pseudo-random operands against the language's own / and %.
        for (int i = 0; i < 16; i++) begin
            ra = {$urandom, $urandom};
            if (i % 3 == 0)
                rb = 64'($urandom_range(1000, 1));
            else if (i % 3 == 1)
                rb = {32'd0, $urandom | 32'd1};
            else
                rb = {$urandom | 32'h1, $urandom};
            do_op(ra, rb, lat);
            rq = bus.c[W-1:0];
            rr = bus.c[2*W-1:W];
            check("rand latency", 128'(lat), 128'd65);
            check("rand quotient", 128'(rq), 128'(ra / rb));
            check("rand remainder", 128'(rr), 128'(ra % rb));
            check("rand identity", 128'(rq * rb + rr), 128'(ra));
            check("rand rem<b", 128'(rr < rb), 128'd1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
